// File: rtl/id_ex_alu_issue_if.sv
// rtl/id_ex_alu_issue_if.sv - ID-side inputs and EX-side ALU/side-band outputs of the ID/EX boundary
interface id_ex_alu_issue_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [31:0]      id_instr;
    logic [31:0]      id_pc;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;

    logic             ex_valid;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_ctrl;
    logic [4:0]       ex_rd;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic [31:0]      store_data;
    logic             branch;
    logic [2:0]       br_funct3;
    logic             illegal;
    logic [CNT_W-1:0] issued_cnt;

    // master is the issue stage (drives EX side), slave is the EX stage
    modport master (
        input  id_valid, id_instr, id_pc, rs1_data, rs2_data,
        output ex_valid, alu_a, alu_b, alu_ctrl, ex_rd, reg_write, mem_read,
               mem_write, store_data, branch, br_funct3, illegal, issued_cnt
    );
    modport slave (
        output id_valid, id_instr, id_pc, rs1_data, rs2_data,
        input  ex_valid, alu_a, alu_b, alu_ctrl, ex_rd, reg_write, mem_read,
               mem_write, store_data, branch, br_funct3, illegal, issued_cnt
    );
endinterface

// File: rtl/id_ex_alu_issue.sv
// rtl/id_ex_alu_issue.sv - RV32I ID decode to ALU control/operands, registered at the ID/EX boundary
module id_ex_alu_issue #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    id_ex_alu_issue_if.master  bus
);
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] sd;
        logic        br;
        logic [2:0]  f3;
        logic        ill;
    } ex_t;

    function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_fn = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_fn = ALU_SLL;
            3'b010:  alu_fn = ALU_SLT;
            3'b011:  alu_fn = ALU_SLTU;
            3'b100:  alu_fn = ALU_XOR;
            3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic        writes_rd;
    ex_t         dec;
    ex_t         ex_q;
    logic [CNT_W-1:0] cnt_q;

    assign opcode = bus.id_instr[6:0];
    assign funct3 = bus.id_instr[14:12];
    assign funct7 = bus.id_instr[31:25];
    assign rd     = bus.id_instr[11:7];
    assign imm_i  = {{20{bus.id_instr[31]}}, bus.id_instr[31:20]};
    assign imm_s  = {{20{bus.id_instr[31]}}, bus.id_instr[31:25], bus.id_instr[11:7]};
    assign imm_u  = {bus.id_instr[31:12], 12'b0};

    always_comb begin
        dec       = '0;
        writes_rd = 1'b0;
        dec.valid = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec.a = bus.rs1_data;
                dec.b = bus.rs2_data;
                writes_rd = 1'b1;
                if (funct7 == 7'b0000000)
                    dec.ctrl = alu_fn(funct3, 1'b0);
                else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
                    dec.ctrl = alu_fn(funct3, 1'b1);
                else
                    dec.ill = 1'b1;
            end
            OPC_OPIMM: begin
                dec.a = bus.rs1_data;
                dec.b = imm_i;
                writes_rd = 1'b1;
                // imm[11:5] doubles as the shift-type field for shift immediates
                if (funct3 == 3'b001)
                    dec.ctrl = (funct7 == 7'b0000000) ? ALU_SLL : ALU_AND;
                else if (funct3 == 3'b101)
                    dec.ctrl = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
                else
                    dec.ctrl = alu_fn(funct3, 1'b0);
                if (funct3 == 3'b001 && funct7 != 7'b0000000)
                    dec.ill = 1'b1;
                if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    dec.ill = 1'b1;
            end
            OPC_LUI: begin
                dec.b     = imm_u;
                dec.ctrl  = ALU_PASSB;
                writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a     = bus.id_pc;
                dec.b     = imm_u;
                dec.ctrl  = ALU_ADD;
                writes_rd = 1'b1;
            end
            OPC_LOAD: begin
                dec.a     = bus.rs1_data;
                dec.b     = imm_i;
                dec.ctrl  = ALU_ADD;
                dec.mr    = 1'b1;
                writes_rd = 1'b1;
                dec.ill   = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec.a    = bus.rs1_data;
                dec.b    = imm_s;
                dec.ctrl = ALU_ADD;
                dec.mw   = 1'b1;
                dec.sd   = bus.rs2_data;
                dec.ill  = (funct3[2] || funct3 == 3'b011);
            end
            OPC_BRANCH: begin
                dec.a  = bus.rs1_data;
                dec.b  = bus.rs2_data;
                dec.br = 1'b1;
                dec.f3 = funct3;
                case (funct3[2:1])
                    2'b00:   dec.ctrl = ALU_SUB;
                    2'b10:   dec.ctrl = ALU_SLT;
                    2'b11:   dec.ctrl = ALU_SLTU;
                    default: dec.ill  = 1'b1;
                endcase
            end
            default: dec.ill = 1'b1;
        endcase
        if (writes_rd) begin
            dec.rd = rd;
            dec.rw = (rd != 5'd0);
        end
        // an illegal encoding still occupies the EX slot, but carries no operands or enables
        if (dec.ill) begin
            dec       = '0;
            dec.valid = 1'b1;
            dec.ill   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            ex_q <= '0;
        end else if (!stall) begin
            ex_q <= bus.id_valid ? dec : '0;
            if (bus.id_valid && !dec.ill && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.ex_valid   = ex_q.valid;
    assign bus.alu_a      = ex_q.a;
    assign bus.alu_b      = ex_q.b;
    assign bus.alu_ctrl   = ex_q.ctrl;
    assign bus.ex_rd      = ex_q.rd;
    assign bus.reg_write  = ex_q.rw;
    assign bus.mem_read   = ex_q.mr;
    assign bus.mem_write  = ex_q.mw;
    assign bus.store_data = ex_q.sd;
    assign bus.branch     = ex_q.br;
    assign bus.br_funct3  = ex_q.f3;
    assign bus.illegal    = ex_q.ill;
    assign bus.issued_cnt = cnt_q;
endmodule
